mem_arbiter: RTL
================

# mem_arbiter

Two-port-to-one memory arbiter placed between the pipelined ARM core and a single shared, variable-latency memory. Sequences instruction fetches (Fetch stage) and data loads/stores (Memory stage) onto one request/acknowledge memory port. Returns per-port wait signals that the hazard unit ORs into its stall terms. Data accesses take fixed priority over fetches.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; forces state to IDLE
- IReqF  in  1  fetch request; held with IAddrF stable while IWaitF=1
- IAddrF  in  ADDR_W  fetch address (PCF)
- IRdataF  out  DATA_W  fetched instruction, valid when IReqF=1 and IWaitF=0
- IWaitF  out  1  fetch not yet complete
- DReqM  in  1  data request; fields held stable while DWaitM=1
- DWeM  in  1  1 = store, 0 = load
- DAddrM  in  ADDR_W  data address (ALUOutM)
- DWdataM  in  DATA_W  store data (WriteDataM)
- DRdataM  out  DATA_W  load data, valid when DReqM=1 and DWaitM=0
- DWaitM  out  1  data access not yet complete
- MReq  out  1  memory request, held until MAck
- MWe  out  1  memory write enable
- MAddr  out  ADDR_W  memory address
- MWdata  out  DATA_W  memory write data
- MRdata  in  DATA_W  memory read data, valid with MAck
- MAck  in  1  one-cycle completion pulse, only while MReq=1

## Operation
- FSM states: IDLE, IBUSY, DBUSY, IDONE, DDONE.
- IDLE: DReqM=1 -> DBUSY. Else IReqF=1 -> IBUSY. Else stay.
- On the transition, MReq/MWe/MAddr/MWdata are registered from the winning port. MWe=0 for fetches.
- xBUSY: MReq=1 and all memory-side outputs hold. On MAck, capture MRdata into that port's rdata register (loads/fetches only) -> xDONE. MReq drops to 0 the same edge.
- IDONE: IWaitF=0, so the fetch is consumed this cycle. Next: DReqM=1 -> DBUSY, else IDLE.
- DDONE: DWaitM=0. Next: IReqF=1 -> IBUSY, else IDLE.
- The just-served port is never re-granted directly from its DONE state. Its next request is seen in IDLE.
- IWaitF = IReqF & (state != IDONE). DWaitM = DReqM & (state != DDONE). Both are combinational.
- Stores: DRdataM keeps its previous value.
- IRdataF and DRdataM are registers and hold their value until the next capture for their port.
- Request withdrawn mid-transaction (flush, e.g. branch in Execute drops IReqF):
  - the memory transaction still completes;
  - the FSM still passes through xDONE;
  - the captured data is ignored by the requester.
  A store is never cancelled once in DBUSY.
- Simultaneous IReqF and DReqM in IDLE: data wins. The fetch waits through DBUSY/DDONE and is then granted from DDONE.

## Timing
- Reset (asserted, async) values:
  - state=IDLE
  - MReq=0, MWe=0, MAddr=0, MWdata=0
  - IRdataF=0, DRdataM=0
  - IWaitF=IReqF, DWaitM=DReqM
- Best-case access, MAck in the first MReq cycle:
  - request seen in cycle 0 (IDLE);
  - MReq high in cycle 1, MAck in cycle 1;
  - wait low and data valid in cycle 2.
  The requester therefore sees 2 wait cycles.
- A memory taking N cycles to ack (N>=1 counted from MReq rise) gives N+1 wait cycles.
- Back-to-back fetches, no data traffic: one fetch per 3 cycles (IDLE, IBUSY, IDONE) with single-cycle memory.
- Alternating D/I: DDONE -> IBUSY directly, no IDLE bubble.
- Reset asserted mid-transaction: MReq drops asynchronously and the outstanding transaction is abandoned. The memory model must discard any later MAck.
- MAck while MReq=0: ignored, no state change.

## Structure
- Shared package arm_mem_pkg:
  - arb_state_t enum (IDLE, IBUSY, DBUSY, IDONE, DDONE);
  - ADDR_W/DATA_W default constants.
- Single module, no sub-module.
- Three concerns:
  - FSM next-state logic;
  - memory-side request register bank;
  - two capture registers for the read data.

## Test plan
- Single load, memory acks in its first cycle: DReqM=1, DAddrM=0x100, MRdata=0xDEADBEEF -> MReq cycles 1..1, DWaitM=1 in cycles 0–1, DWaitM=0 and DRdataM=0xDEADBEEF in cycle 2.
- Simultaneous IReqF (0x0) and store DReqM (0x200, data 0x55) in IDLE, memory latency 3 -> store issued first with MWe=1. Fetch MReq rises in the cycle after DDONE. IWaitF stays high for 8 cycles total.
- Fetch flushed mid-IBUSY: IReqF dropped in cycle 2 of a 4-cycle memory -> MReq held until MAck, state passes IDONE -> IDLE, no spurious MReq.
- Back-to-back fetches at 0x0, 0x4, 0x8 with zero extra latency -> one IRdataF update every 3 cycles, correct instruction words.
- Reset pulsed low during DBUSY -> MReq=0 immediately, rdata registers 0, next DReqM restarts from IDLE. A late MAck is ignored.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and default widths for the ARM core memory arbiter.
package arm_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IBUSY = 3'd1,
    DBUSY = 3'd2,
    IDONE = 3'd3,
    DDONE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates Fetch-stage and Memory-stage accesses onto one req/ack memory port;
// data accesses win over fetches, and a served port is never re-granted from its DONE state.
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReqF,
  input  logic [ADDR_W-1:0] IAddrF,
  output logic [DATA_W-1:0] IRdataF,
  output logic              IWaitF,
  input  logic              DReqM,
  input  logic              DWeM,
  input  logic [ADDR_W-1:0] DAddrM,
  input  logic [DATA_W-1:0] DWdataM,
  output logic [DATA_W-1:0] DRdataM,
  output logic              DWaitM,
  output logic              MReq,
  output logic              MWe,
  output logic [ADDR_W-1:0] MAddr,
  output logic [DATA_W-1:0] MWdata,
  input  logic [DATA_W-1:0] MRdata,
  input  logic              MAck
);

  arb_state_t        state_q, state_d;
  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;

  logic ack;
  logic grant_d;
  logic grant_i;

  // An ack only counts while a request is actually outstanding.
  assign ack     = MAck & mreq_q;
  assign grant_d = DReqM & ((state_q == IDLE) | (state_q == IDONE));
  assign grant_i = IReqF & (((state_q == IDLE) & ~DReqM) | (state_q == DDONE));

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (DReqM)      state_d = DBUSY;
        else if (IReqF) state_d = IBUSY;
      end
      IBUSY:   if (ack) state_d = IDONE;
      DBUSY:   if (ack) state_d = DDONE;
      IDONE:   state_d = DReqM ? DBUSY : IDLE;
      DDONE:   state_d = IReqF ? IBUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side request bank and read-data capture
  always_comb begin
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    if (grant_d) begin
      mreq_d   = 1'b1;
      mwe_d    = DWeM;
      maddr_d  = DAddrM;
      mwdata_d = DWdataM;
    end else if (grant_i) begin
      mreq_d  = 1'b1;
      mwe_d   = 1'b0;
      maddr_d = IAddrF;
    end else if (ack) begin
      mreq_d = 1'b0;
    end
    if (ack && (state_q == IBUSY)) irdata_d = MRdata;
    if (ack && (state_q == DBUSY) && !mwe_q) drdata_d = MRdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign MReq    = mreq_q;
  assign MWe     = mwe_q;
  assign MAddr   = maddr_q;
  assign MWdata  = mwdata_q;
  assign IRdataF = irdata_q;
  assign DRdataM = drdata_q;
  assign IWaitF  = IReqF & (state_q != IDONE);
  assign DWaitM  = DReqM & (state_q != DDONE);

endmodule
